// File: rtl/utlb_if.sv
// utlb_if: request, mmu search and response signals of the micro-TLB.
// Slave modport is the utlb side; master is the requester/mmu side.
interface utlb_if;
  logic        req_valid_i;
  logic [31:0] req_vaddr_i;
  logic        req_ready_o;
  logic [9:0]  asid_i;
  logic        flush_i;

  logic        mmu_req_valid_o;
  logic [31:0] mmu_vaddr_o;
  logic        mmu_found_i;
  logic [31:0] mmu_paddr_i;
  logic [5:0]  mmu_ps_i;
  logic        mmu_v_i;
  logic        mmu_d_i;
  logic [1:0]  mmu_plv_i;
  logic [1:0]  mmu_mat_i;

  logic        resp_valid_o;
  logic [31:0] resp_paddr_o;
  logic        resp_found_o;
  logic        resp_v_o;
  logic        resp_d_o;
  logic [1:0]  resp_plv_o;
  logic [1:0]  resp_mat_o;

  modport slave (
    input  req_valid_i, req_vaddr_i, asid_i, flush_i,
    input  mmu_found_i, mmu_paddr_i, mmu_ps_i, mmu_v_i, mmu_d_i, mmu_plv_i, mmu_mat_i,
    output req_ready_o, mmu_req_valid_o, mmu_vaddr_o,
    output resp_valid_o, resp_paddr_o, resp_found_o, resp_v_o, resp_d_o, resp_plv_o, resp_mat_o
  );

  modport master (
    output req_valid_i, req_vaddr_i, asid_i, flush_i,
    output mmu_found_i, mmu_paddr_i, mmu_ps_i, mmu_v_i, mmu_d_i, mmu_plv_i, mmu_mat_i,
    input  req_ready_o, mmu_req_valid_o, mmu_vaddr_o,
    input  resp_valid_o, resp_paddr_o, resp_found_o, resp_v_o, resp_d_o, resp_plv_o, resp_mat_o
  );
endinterface

// File: rtl/utlb.sv
// utlb: fully-associative micro-TLB (4KB/4MB pages) in front of the mmu search port.
// Define UTLB_PERF_CNT_EN to add the hit_cnt_o / miss_cnt_o performance counters.
module utlb #(
  parameter int unsigned ENTRY_NUM = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  utlb_if.slave       bus
`ifdef UTLB_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);
  localparam int unsigned IDX_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

  typedef enum logic [1:0] {IDLE, LOOK, WALK, RESP} state_t;

  typedef struct packed {
    logic        valid;
    logic [19:0] vpn;
    logic        is4m;
    logic [19:0] ppn;
    logic        d;
    logic [1:0]  plv;
    logic [1:0]  mat;
  } entry_t;

  typedef struct packed {
    logic        found;
    logic [31:0] paddr;
    logic        v;
    logic        d;
    logic [1:0]  plv;
    logic [1:0]  mat;
  } walk_t;

  state_t           state_q, state_d;
  entry_t           tlb_q [ENTRY_NUM];
  walk_t            walk_q;
  logic [31:0]      vaddr_q;
  logic [9:0]       asid_q;
  logic [IDX_W-1:0] rr_q;

  logic             hit, ready, accept, inval, fill, use_rr;
  logic [IDX_W-1:0] hit_idx, victim;
  entry_t           hit_e;
  logic [31:0]      hit_paddr;

  // Associative match of the held vaddr; lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      if (!hit && tlb_q[i].valid &&
          (tlb_q[i].is4m ? (tlb_q[i].vpn[19:10] == vaddr_q[31:22])
                         : (tlb_q[i].vpn == vaddr_q[31:12]))) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign hit_e     = tlb_q[hit_idx];
  assign hit_paddr = hit_e.is4m ? {hit_e.ppn[19:10], vaddr_q[21:0]}
                                : {hit_e.ppn, vaddr_q[11:0]};

  // Victim: lowest invalid slot, else the round-robin pointer.
  always_comb begin
    victim = rr_q;
    use_rr = 1'b1;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      if (use_rr && !tlb_q[i].valid) begin
        victim = IDX_W'(i);
        use_rr = 1'b0;
      end
    end
  end

  // A flush or ASID switch beats a fill landing on the same edge.
  assign inval = bus.flush_i || (bus.asid_i != asid_q);
  assign fill  = (state_q == WALK) && bus.mmu_found_i && bus.mmu_v_i && !inval;

  always_comb begin
    state_d              = state_q;
    ready                = 1'b0;
    bus.mmu_req_valid_o  = 1'b0;
    bus.mmu_vaddr_o      = '0;
    bus.resp_valid_o     = 1'b0;
    bus.resp_paddr_o     = '0;
    bus.resp_found_o     = 1'b0;
    bus.resp_v_o         = 1'b0;
    bus.resp_d_o         = 1'b0;
    bus.resp_plv_o       = '0;
    bus.resp_mat_o       = '0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.req_valid_i) state_d = LOOK;
      end
      LOOK: begin
        if (hit) begin
          ready            = 1'b1;
          bus.resp_valid_o = 1'b1;
          bus.resp_paddr_o = hit_paddr;
          bus.resp_found_o = 1'b1;
          bus.resp_v_o     = 1'b1;
          bus.resp_d_o     = hit_e.d;
          bus.resp_plv_o   = hit_e.plv;
          bus.resp_mat_o   = hit_e.mat;
          state_d          = bus.req_valid_i ? LOOK : IDLE;
        end else begin
          state_d = WALK;
        end
      end
      WALK: begin
        bus.mmu_req_valid_o = 1'b1;
        bus.mmu_vaddr_o     = vaddr_q;
        state_d             = RESP;
      end
      RESP: begin
        bus.resp_valid_o = 1'b1;
        bus.resp_paddr_o = walk_q.paddr;
        bus.resp_found_o = walk_q.found;
        bus.resp_v_o     = walk_q.v;
        bus.resp_d_o     = walk_q.d;
        bus.resp_plv_o   = walk_q.plv;
        bus.resp_mat_o   = walk_q.mat;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready_o = ready;
  assign accept          = bus.req_valid_i && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vaddr_q <= '0;
      walk_q  <= '0;
      asid_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      asid_q  <= bus.asid_i;
      if (accept) vaddr_q <= bus.req_vaddr_i;
      if (state_q == WALK) begin
        walk_q <= '{found: bus.mmu_found_i, paddr: bus.mmu_paddr_i, v: bus.mmu_v_i,
                    d: bus.mmu_d_i, plv: bus.mmu_plv_i, mat: bus.mmu_mat_i};
      end
      if (fill && use_rr) rr_q <= rr_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRY_NUM; i++) tlb_q[i] <= '0;
    end else if (inval) begin
      for (int unsigned i = 0; i < ENTRY_NUM; i++) tlb_q[i].valid <= 1'b0;
    end else if (fill) begin
      tlb_q[victim] <= '{valid: 1'b1, vpn: vaddr_q[31:12], is4m: (bus.mmu_ps_i == 6'd21),
                         ppn: bus.mmu_paddr_i[31:12], d: bus.mmu_d_i,
                         plv: bus.mmu_plv_i, mat: bus.mmu_mat_i};
    end
  end

`ifdef UTLB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (state_q == LOOK) begin
      if (hit) hit_cnt_o  <= hit_cnt_o + 32'd1;
      else     miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_utlb.sv
// tb_utlb: directed scoreboard bench for utlb; the bench plays both requester and mmu.
module tb_utlb;
  logic clk;
  logic rst_n;

  utlb_if bus ();

`ifdef UTLB_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  utlb #(.ENTRY_NUM(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef UTLB_PERF_CNT_EN
    ,
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
`endif
  );

  typedef struct {
    logic [31:0] paddr;
    logic [6:0]  attr;
    int          lat;
  } exp_t;

  exp_t        sb [$];
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;
  int          walk_cnt = 0;
  int          exp_walks = 0;
  logic [31:0] last_walk_va = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mmu side observer: counts completed walks and records the searched vaddr
  always @(posedge clk) begin
    if (bus.mmu_req_valid_o) begin
      walk_cnt     <= walk_cnt + 1;
      last_walk_va <= bus.mmu_vaddr_o;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [6:0] mk_attr(input logic f, input logic v, input logic d,
                                         input logic [1:0] plv, input logic [1:0] mat);
    return {f, v, d, plv, mat};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mmu(input logic f, input logic v, input logic [31:0] pa, input logic [5:0] ps,
                         input logic d, input logic [1:0] plv, input logic [1:0] mat);
    bus.mmu_found_i = f;
    bus.mmu_v_i     = v;
    bus.mmu_paddr_i = pa;
    bus.mmu_ps_i    = ps;
    bus.mmu_d_i     = d;
    bus.mmu_plv_i   = plv;
    bus.mmu_mat_i   = mat;
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (bus.resp_valid_o && sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_paddr"}, 64'(bus.resp_paddr_o), 64'(e.paddr));
      chk({tag, "_attr"}, 64'({bus.resp_found_o, bus.resp_v_o, bus.resp_d_o,
                               bus.resp_plv_o, bus.resp_mat_o}), 64'(e.attr));
    end else begin
      chk({tag, "_resp_valid"}, 64'(bus.resp_valid_o), 64'(sb.size() != 0));
    end
  endtask

  // One request from IDLE; flush_i is held high over the posedge ending cycle flush_at.
  task automatic txn(input logic [31:0] va, input logic [31:0] pa, input logic [6:0] at,
                     input int lat, input int flush_at);
    exp_t e;
    bit   seen;
    chk("req_ready_idle", 64'(bus.req_ready_o), 64'd1);
    sb.push_back('{paddr: pa, attr: at, lat: lat});
    if (lat > 1) exp_walks = exp_walks + 1;
    bus.req_valid_i = 1'b1;
    bus.req_vaddr_i = va;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_vaddr_i = '0;
    seen = 1'b0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      if (bus.resp_valid_o) begin
        e = sb.pop_front();
        chk("resp_paddr", 64'(bus.resp_paddr_o), 64'(e.paddr));
        chk("resp_attr", 64'({bus.resp_found_o, bus.resp_v_o, bus.resp_d_o,
                              bus.resp_plv_o, bus.resp_mat_o}), 64'(e.attr));
        chk("resp_latency", 64'(c), 64'(e.lat));
        seen = 1'b1;
      end else begin
        chk("resp_idle_zero", 64'({bus.resp_paddr_o, bus.resp_found_o, bus.resp_v_o,
                                   bus.resp_d_o, bus.resp_plv_o, bus.resp_mat_o}), 64'd0);
        if (!bus.mmu_req_valid_o) chk("mmu_vaddr_zero", 64'(bus.mmu_vaddr_o), 64'd0);
        bus.flush_i = (c == flush_at);
        @(negedge clk);
      end
    end
    bus.flush_i = 1'b0;
    if (!seen) begin
      chk("resp_timeout", 64'd0, 64'd1);
      sb.delete();
    end
    @(negedge clk);
    chk("walk_count", 64'(walk_cnt), 64'(exp_walks));
    if (lat > 1 && seen) chk("walk_vaddr", 64'(last_walk_va), 64'(va));
  endtask

  initial begin
    int resp_seen;
    rst_n           = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_vaddr_i = '0;
    bus.asid_i      = 10'h001;
    bus.flush_i     = 1'b0;
    set_mmu(1'b0, 1'b0, 32'h0, 6'd12, 1'b0, 2'd0, 2'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    chk("rst_ready", 64'(bus.req_ready_o), 64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("rst_mmu_valid", 64'(bus.mmu_req_valid_o), 64'd0);
    chk("rst_data_zero", 64'({bus.resp_paddr_o, bus.mmu_vaddr_o}), 64'd0);

    // cold miss, then 1-cycle hit on the same 4KB page with a poisoned mmu
    set_mmu(1'b1, 1'b1, 32'h1C00_0000, 6'd12, 1'b1, 2'd3, 2'd1);
    txn(32'h0040_1234, 32'h1C00_0000, mk_attr(1, 1, 1, 2'd3, 2'd1), 3, 0);
    set_mmu(1'b0, 1'b0, 32'hDEAD_0000, 6'd12, 1'b0, 2'd0, 2'd0);
    txn(32'h0040_1ABC, 32'h1C00_0ABC, mk_attr(1, 1, 1, 2'd3, 2'd1), 1, 0);

    // 4MB page
    set_mmu(1'b1, 1'b1, 32'h0040_0000, 6'd21, 1'b0, 2'd2, 2'd2);
    txn(32'h8040_0000, 32'h0040_0000, mk_attr(1, 1, 0, 2'd2, 2'd2), 3, 0);
    set_mmu(1'b0, 1'b0, 32'hDEAD_0000, 6'd12, 1'b0, 2'd0, 2'd0);
    txn(32'h807F_FFF0, 32'h007F_FFF0, mk_attr(1, 1, 0, 2'd2, 2'd2), 1, 0);

    // not found is reported and never cached
    set_mmu(1'b0, 1'b1, 32'h0ABC_D000, 6'd12, 1'b0, 2'd1, 2'd0);
    txn(32'h1234_5678, 32'h0ABC_D000, mk_attr(0, 1, 0, 2'd1, 2'd0), 3, 0);
    txn(32'h1234_5678, 32'h0ABC_D000, mk_attr(0, 1, 0, 2'd1, 2'd0), 3, 0);

    // fill to capacity plus one: entry 0 page is evicted, newest page hits
    set_mmu(1'b1, 1'b1, 32'h2A00_0000, 6'd12, 1'b0, 2'd0, 2'd1);
    txn(32'h00A0_0000, 32'h2A00_0000, mk_attr(1, 1, 0, 2'd0, 2'd1), 3, 0);
    set_mmu(1'b1, 1'b1, 32'h2B00_0000, 6'd12, 1'b0, 2'd0, 2'd1);
    txn(32'h00B0_0000, 32'h2B00_0000, mk_attr(1, 1, 0, 2'd0, 2'd1), 3, 0);
    set_mmu(1'b1, 1'b1, 32'h2C00_0000, 6'd12, 1'b0, 2'd0, 2'd1);
    txn(32'h00C0_0000, 32'h2C00_0000, mk_attr(1, 1, 0, 2'd0, 2'd1), 3, 0);
    txn(32'h00C0_0444, 32'h2C00_0444, mk_attr(1, 1, 0, 2'd0, 2'd1), 1, 0);
    set_mmu(1'b1, 1'b1, 32'h1C00_0000, 6'd12, 1'b1, 2'd3, 2'd1);
    txn(32'h0040_1000, 32'h1C00_0000, mk_attr(1, 1, 1, 2'd3, 2'd1), 3, 0);

    // flush during WALK: response still delivered, translation not kept
    set_mmu(1'b1, 1'b1, 32'h5555_5000, 6'd12, 1'b1, 2'd1, 2'd1);
    txn(32'h0D00_0123, 32'h5555_5000, mk_attr(1, 1, 1, 2'd1, 2'd1), 3, 2);
    txn(32'h0D00_0123, 32'h5555_5000, mk_attr(1, 1, 1, 2'd1, 2'd1), 3, 0);
    txn(32'h0D00_0456, 32'h5555_5456, mk_attr(1, 1, 1, 2'd1, 2'd1), 1, 0);

    // ASID switch invalidates everything
    bus.asid_i = 10'h002;
    @(negedge clk);
    txn(32'h0D00_0456, 32'h5555_5000, mk_attr(1, 1, 1, 2'd1, 2'd1), 3, 0);
    set_mmu(1'b1, 1'b1, 32'h6666_6000, 6'd12, 1'b1, 2'd1, 2'd1);
    txn(32'h0E00_0000, 32'h6666_6000, mk_attr(1, 1, 1, 2'd1, 2'd1), 3, 0);

    // back-to-back hits on consecutive cycles
    sb.push_back('{paddr: 32'h5555_5010, attr: mk_attr(1, 1, 1, 2'd1, 2'd1), lat: 1});
    sb.push_back('{paddr: 32'h6666_6020, attr: mk_attr(1, 1, 1, 2'd1, 2'd1), lat: 1});
    sb.push_back('{paddr: 32'h5555_5030, attr: mk_attr(1, 1, 1, 2'd1, 2'd1), lat: 1});
    chk("b2b_ready_idle", 64'(bus.req_ready_o), 64'd1);
    bus.req_valid_i = 1'b1;
    bus.req_vaddr_i = 32'h0D00_0010;
    @(negedge clk);
    pop_chk("b2b_a");
    chk("b2b_ready_on_hit", 64'(bus.req_ready_o), 64'd1);
    bus.req_vaddr_i = 32'h0E00_0020;
    @(negedge clk);
    pop_chk("b2b_b");
    bus.req_vaddr_i = 32'h0D00_0030;
    @(negedge clk);
    pop_chk("b2b_c");
    bus.req_valid_i = 1'b0;
    bus.req_vaddr_i = '0;
    @(negedge clk);
    chk("b2b_end_idle", 64'(bus.resp_valid_o), 64'd0);
    chk("b2b_queue_empty", 64'(sb.size()), 64'd0);

    // reset while walking: no response, nothing filled
    set_mmu(1'b1, 1'b1, 32'h7777_7000, 6'd12, 1'b0, 2'd0, 2'd3);
    bus.req_valid_i = 1'b1;
    bus.req_vaddr_i = 32'h0F00_0000;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_vaddr_i = '0;
    @(negedge clk);
    chk("rst_walk_active", 64'(bus.mmu_req_valid_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_resp", 64'(bus.resp_valid_o), 64'd0);
    chk("rst_async_ready", 64'(bus.req_ready_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    resp_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.resp_valid_o) resp_seen = resp_seen + 1;
    end
    chk("rst_no_resp", 64'(resp_seen), 64'd0);
    chk("rst_walk_count", 64'(walk_cnt), 64'(exp_walks));
    txn(32'h0F00_0000, 32'h7777_7000, mk_attr(1, 1, 0, 2'd0, 2'd3), 3, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
